fetch_sequencer: RTL

Instruction fetch and timing sequencer for the 4-bit microcontroller. It drives the program counter and the synchronous program-memory read, and latches each 8-bit instruction word into the instruction register. It generates the four-phase T0–T3 timing code. Its `instruction` and `Timing_Signal` outputs feed the control decoder directly, which fires its one-hot control word in T2.

---
 rtl/mcu_pkg.sv | 21 ++
 rtl/program_counter.sv | 35 +++
 rtl/fetch_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// mcu_pkg: definitions shared across the 4-bit microcontroller.
//   - Timing_Signal phase encodings (T0..T3)
//   - opcode and instruction word widths
//   - bit positions of the opcode and operand fields in an instruction word
package mcu_pkg;

  localparam int MCU_OPCODE_W = 4;
  localparam int MCU_IW       = 8;

  // Instruction word layout: opcode in the upper nibble, operand in the lower.
  localparam int OPCODE_MSB  = 7;
  localparam int OPCODE_LSB  = 4;
  localparam int OPERAND_MSB = 3;
  localparam int OPERAND_LSB = 0;

  localparam logic [1:0] TS_T0 = 2'b00;
  localparam logic [1:0] TS_T1 = 2'b01;
  localparam logic [1:0] TS_T2 = 2'b10;
  localparam logic [1:0] TS_T3 = 2'b11;

endpackage

// File: rtl/program_counter.sv
// program_counter: ADDR_W-bit program counter.
//   clk, rst_n  : clock, asynchronous active-low reset (PC clears to 0)
//   load        : load pc from load_val; wins over inc
//   load_val    : value to load
//   inc         : advance pc by one, wrapping from all-ones to zero
//   pc          : current program counter
//   wrap        : high while an increment in this cycle will wrap pc to zero
module program_counter #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic              wrap
);

  logic [ADDR_W-1:0] pc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= '0;
    end else if (load) begin
      pc_reg <= load_val;
    end else if (inc) begin
      pc_reg <= pc_reg + ADDR_W'(1);
    end
  end

  assign pc   = pc_reg;
  assign wrap = inc && (pc_reg == {ADDR_W{1'b1}});

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch and T0-T3 timing sequencer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   run                 : level, continuous execution while high
//   step                : one-cycle pulse, executes one instruction from IDLE
//   pc_load, pc_load_val: PC load request (honoured in IDLE and T3 only)
//   mem_addr, mem_rd    : program-memory address (= pc) and read strobe (T0)
//   mem_data            : read data, one cycle after mem_rd
//   instruction, operand: IR opcode / operand fields for the decoder
//   Timing_Signal       : phase code, 00 in IDLE and T0
//   pc                  : current program counter
//   halted              : high in IDLE
//   instr_done          : high in T3
module fetch_sequencer
  import mcu_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int IW           = MCU_IW,
  parameter bit HALT_ON_WRAP = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    step,
  input  logic                    pc_load,
  input  logic [ADDR_W-1:0]       pc_load_val,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd,
  input  logic [IW-1:0]           mem_data,
  output logic [MCU_OPCODE_W-1:0] instruction,
  output logic [3:0]              operand,
  output logic [1:0]              Timing_Signal,
  output logic [ADDR_W-1:0]       pc,
  output logic                    halted,
  output logic                    instr_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3
  } state_t;

  state_t        state_reg, state_next;
  logic          single_reg, single_next;
  // Set when this instruction's PC increment wrapped to zero.
  logic          wrapped_reg, wrapped_next;
  logic [IW-1:0] ir_reg;

  logic pc_ld, pc_inc, pc_wrap, ir_ld;

  program_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_ld),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc),
    .wrap     (pc_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      single_reg  <= 1'b0;
      wrapped_reg <= 1'b0;
      ir_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      single_reg  <= single_next;
      wrapped_reg <= wrapped_next;
      if (ir_ld) begin
        ir_reg <= mem_data;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    single_next  = single_reg;
    wrapped_next = wrapped_reg;
    pc_ld        = 1'b0;
    pc_inc       = 1'b0;
    ir_ld        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        wrapped_next = 1'b0;
        // A load in IDLE consumes the cycle; starting waits for the next one.
        if (pc_load) begin
          pc_ld = 1'b1;
        end else if (run) begin
          state_next  = S_T0;
          single_next = 1'b0;
        end else if (step) begin
          state_next  = S_T0;
          single_next = 1'b1;
        end
      end
      S_T0: state_next = S_T1;
      S_T1: begin
        // Memory data requested in T0 is valid now; capture it with the PC bump.
        state_next = S_T2;
        ir_ld      = 1'b1;
        pc_inc     = 1'b1;
        if (pc_wrap) begin
          wrapped_next = 1'b1;
        end
      end
      S_T2: state_next = S_T3;
      S_T3: begin
        single_next  = 1'b0;
        wrapped_next = 1'b0;
        if (pc_load) begin
          pc_ld      = 1'b1;
          state_next = (run && !single_reg) ? S_T0 : S_IDLE;
        end else if (HALT_ON_WRAP && wrapped_reg) begin
          state_next = S_IDLE;
        end else if (run && !single_reg) begin
          state_next = S_T0;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    Timing_Signal = TS_T0;
    case (state_reg)
      S_T1:    Timing_Signal = TS_T1;
      S_T2:    Timing_Signal = TS_T2;
      S_T3:    Timing_Signal = TS_T3;
      default: Timing_Signal = TS_T0;
    endcase
  end

  assign mem_addr    = pc;
  assign mem_rd      = (state_reg == S_T0);
  assign halted      = (state_reg == S_IDLE);
  assign instr_done  = (state_reg == S_T3);
  assign instruction = ir_reg[OPCODE_MSB:OPCODE_LSB];
  assign operand     = ir_reg[OPERAND_MSB:OPERAND_LSB];

endmodule
